// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling engine.
//   pool_mode_e : pooling operator selection (average / max)
//   idx_w()     : counter/index width for a range of n entries (min 1 bit)
package pool_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_lane_combine.sv
// Combines two signed operands of one lane.
//   mode : POOL_MAX -> signed max, sign-extended to IN_W+1 bits
//          POOL_AVG -> sign-extended sum, IN_W+1 bits (no overflow possible)
//   a, b : signed operands, IN_W bits
//   y    : signed result, IN_W+1 bits
module pool_lane_combine
    import pool_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  pool_mode_e              mode,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [IN_W:0]    y
);

    always_comb begin
        y = '0;
        if (mode == POOL_MAX) begin
            y = (a > b) ? {a[IN_W-1], a} : {b[IN_W-1], b};
        end else begin
            y = {a[IN_W-1], a} + {b[IN_W-1], b};
        end
    end

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 pooling engine over raster-ordered feature maps,
// CHANNELS lanes in parallel, max or average pooling selected per frame.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   clear      : synchronous soft clear of counters and output register
//   mode       : 1 = max, 0 = average; latched on the first beat of a frame
//   in_valid / in_ready / in_data    : input stream, lane c at [c*DATA_W +: DATA_W]
//   out_valid / out_ready / out_data : pooled stream, same packing
//   out_last   : marks the final pooled beat of a frame
//   busy       : frame in progress (first pixel accepted, last output not yet taken)
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IMG_W    = 32,
    parameter int unsigned IMG_H    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned CW   = idx_w(IMG_W);
    localparam int unsigned RW   = idx_w(IMG_H);
    localparam int unsigned LBN  = IMG_W / 2;
    localparam int unsigned LBW  = idx_w(LBN);
    localparam int unsigned PW   = DATA_W + 1;

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
        $error("pool2x2_stream: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
        $error("pool2x2_stream: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]                 col;
    logic [RW-1:0]                 row;
    pool_mode_e                    mode_q;
    logic [CHANNELS*DATA_W-1:0]    p;
    logic [CHANNELS*PW-1:0]        linebuf [LBN];
    logic [CHANNELS*PW-1:0]        lb_rd;
    logic [CHANNELS*PW-1:0]        pair_word;
    logic [CHANNELS*DATA_W-1:0]    pooled;
    logic [LBW-1:0]                lb_idx;
    logic                          accept;
    logic                          out_fire;
    logic                          col_end;
    logic                          row_end;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    assign lb_idx   = LBW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic signed [PW-1:0]   pair_res;
        logic signed [PW:0]     row_res;

        pool_lane_combine #(.IN_W(DATA_W)) u_pair (
            .mode (mode_q),
            .a    (p[c*DATA_W +: DATA_W]),
            .b    (in_data[c*DATA_W +: DATA_W]),
            .y    (pair_res)
        );

        pool_lane_combine #(.IN_W(PW)) u_row (
            .mode (mode_q),
            .a    (lb_rd[c*PW +: PW]),
            .b    (pair_res),
            .y    (row_res)
        );

        assign pair_word[c*PW +: PW] = pair_res;
        // Max of sign-extended values fits in DATA_W bits; the 4-way average
        // is the sum arithmetically shifted by 2, i.e. bits [DATA_W+1:2].
        assign pooled[c*DATA_W +: DATA_W] = (mode_q == POOL_MAX)
                                          ? row_res[DATA_W-1:0]
                                          : row_res[DATA_W+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= POOL_AVG;
            p         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= POOL_AVG;
            p         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                if (col == '0 && row == '0) begin
                    mode_q <= pool_mode_e'(mode);
                end
                if (!col[0]) begin
                    p <= in_data;
                end
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // A new result takes precedence over draining the current one.
            if (accept && row[0] && col[0]) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
                out_last  <= row_end && col_end;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // Ordered so a new frame starting as the previous last beat
            // drains keeps busy asserted.
            if (out_fire && out_last) begin
                busy <= 1'b0;
            end
            if (accept) begin
                busy <= 1'b1;
            end
        end
    end

    // Line buffer holds even-row pair partials; intentionally not reset.
    always_ff @(posedge clk) begin
        if (!clear && accept && !row[0] && col[0]) begin
            linebuf[lb_idx] <= pair_word;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
module tb_pool2x2_stream;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CHANNELS = 1;
    localparam int unsigned IMG_W    = 4;
    localparam int unsigned IMG_H    = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        clear = 1'b0;
    logic                        mode = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [CHANNELS*DATA_W-1:0]  in_data = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic [CHANNELS*DATA_W-1:0]  out_data;
    logic                        out_last;
    logic                        busy;

    always #5 clk = ~clk;

    pool2x2_stream #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic             m;
        logic [0:7][7:0]  pix;   // row 0 cols 0..3, then row 1 cols 0..3
        int               e0;
        int               e1;
    } vec_t;

    vec_t       vecs [7];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] outq [$];

    // Record every beat that will be taken on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && !clear && out_valid && out_ready) begin
            outq.push_back({out_last, out_data});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic m,
                           input int p0, input int p1, input int p2, input int p3,
                           input int p4, input int p5, input int p6, input int p7,
                           input int e0, input int e1);
        vecs[k].m      = m;
        vecs[k].pix[0] = 8'(p0); vecs[k].pix[1] = 8'(p1);
        vecs[k].pix[2] = 8'(p2); vecs[k].pix[3] = 8'(p3);
        vecs[k].pix[4] = 8'(p4); vecs[k].pix[5] = 8'(p5);
        vecs[k].pix[6] = 8'(p6); vecs[k].pix[7] = 8'(p7);
        vecs[k].e0     = e0;
        vecs[k].e1     = e1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("in_ready timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int idx, input int d, input int last);
        if (idx >= outq.size()) begin
            check({name, " missing"}, outq.size(), idx + 1);
        end else begin
            check(name, int'($signed(outq[idx][7:0])), d);
            check({name, " last"}, int'(outq[idx][8]), last);
        end
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int k);
        outq.delete();
        mode = vecs[k].m;
        for (int i = 0; i < 8; i++) send_beat(vecs[k].pix[i]);
        settle();
        check($sformatf("v%0d count", k), outq.size(), 2);
        expect_out($sformatf("v%0d out0", k), 0, vecs[k].e0, 0);
        expect_out($sformatf("v%0d out1", k), 1, vecs[k].e1, 1);
        check($sformatf("v%0d busy", k), int'(busy), 0);
    endtask

    initial begin
        //            m  r0c0  r0c1  r0c2  r0c3  r1c0  r1c1  r1c2  r1c3   e0    e1
        set_vec(0, 1'b1,    1,    5,   -3,    2,    7,   -8,    0,    4,    7,    4);
        set_vec(1, 1'b0,    1,    5,   -3,    2,    7,   -8,    0,    4,    1,    0);
        set_vec(2, 1'b0,   -1,   -1,   -1,   -1,   -1,   -1,   -1,   -2,   -1,   -2);
        set_vec(3, 1'b0,  127,  127, -128, -128,  127,  127, -128, -128,  127, -128);
        set_vec(4, 1'b1, -128, -128, -128, -128, -128, -127, -128, -128, -127, -128);
        set_vec(5, 1'b0,   -8,    6,    3,    3,    1,   -4,   -3,   -4,   -2,   -1);
        set_vec(6, 1'b1,   -5,   -6,   10,   -1,   -7,   -9,   -2,   -3,   -5,   10);

        #2 rst = 1'b1;
        #10;
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data",  int'(out_data),  0);
        check("reset out_last",  int'(out_last),  0);
        check("reset busy",      int'(busy),      0);
        check("reset in_ready",  int'(in_ready),  1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_frame(k);

        // Backpressure: stall the output while the input keeps offering beats.
        outq.delete();
        mode = 1'b1;
        out_ready = 1'b0;
        fork
            begin : bp_drive
                for (int i = 0; i < 8; i++) send_beat(vecs[0].pix[i]);
                in_valid = 1'b0;
            end
            begin : bp_stall
                int unsigned n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp out_valid", int'(out_valid), 1);
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check("bp in_ready", int'(in_ready), 0);
                    check("bp hold data", int'($signed(out_data)), 7);
                    check("bp hold last", int'(out_last), 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        settle();
        check("bp count", outq.size(), 2);
        expect_out("bp out0", 0, 7, 0);
        expect_out("bp out1", 1, 4, 1);

        // Mid-frame mode toggles, two frames back-to-back.
        outq.delete();
        mode = 1'b1;
        send_beat(vecs[0].pix[0]);
        mode = 1'b0;
        for (int i = 1; i < 8; i++) send_beat(vecs[0].pix[i]);
        mode = 1'b0;
        send_beat(vecs[1].pix[0]);
        check("b2b busy mid", int'(busy), 1);
        mode = 1'b1;
        for (int i = 1; i < 8; i++) send_beat(vecs[1].pix[i]);
        settle();
        check("b2b count", outq.size(), 4);
        expect_out("b2b f0 out0", 0, 7, 0);
        expect_out("b2b f0 out1", 1, 4, 1);
        expect_out("b2b f1 out0", 2, 1, 0);
        expect_out("b2b f1 out1", 3, 0, 1);
        check("b2b busy end", int'(busy), 0);

        // Asynchronous reset between edges while a result is pending.
        outq.delete();
        out_ready = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 6; i++) send_beat(vecs[0].pix[i]);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre-rst out_valid", int'(out_valid), 1);
        check("pre-rst busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst in_ready", int'(in_ready), 1);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_frame(0);

        // Soft clear mid-frame; a beat offered during clear must be dropped.
        mode = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(vecs[1].pix[i]);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd100;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear out_valid", int'(out_valid), 0);
        check("clear busy", int'(busy), 0);
        run_frame(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
